// File: rtl/rangefinder_pkg.sv
//------------------------------------------------------------------------------
// Module   : rangefinder_pkg
// Purpose  : Shared types and default widths for the rangefinder sample writer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rangefinder_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/rangefinder_sample_hold.sv
//------------------------------------------------------------------------------
// Module   : rangefinder_sample_hold
// Purpose  : One-entry holding register between the sample stream and the
//            Avalon write port, with sticky overflow on dropped samples.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rangefinder_sample_hold
    import rangefinder_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_flush,
    input  logic              i_clr_ovf,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_waitrequest,
    output logic              o_full,
    output logic [DATA_W-1:0] o_data,
    output logic              o_complete,
    output logic              o_loaded,
    output logic              o_overflow
);

    logic              r_full;
    logic [DATA_W-1:0] r_data;
    logic              r_ovf;
    logic              w_complete;
    logic              w_loaded;
    logic              w_drop;

    // A write finishes whenever the entry is presented and the slave does not stall.
    assign w_complete = r_full & ~i_waitrequest;
    // A new sample fits if the entry is empty or is being drained this same cycle.
    assign w_loaded   = i_load & ~i_flush & (~r_full | w_complete);
    assign w_drop     = i_load & ~i_flush & r_full & ~w_complete;

    // Holding entry: flush wins, then load, then drain on completion.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_flush) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (w_loaded) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end else if (w_complete) begin
            r_full <= 1'b0;
        end
    end

    // Sticky overflow: set by any dropped sample, cleared only by a new capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf <= 1'b0;
        end else if (i_clr_ovf) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end
    end

    assign o_full     = r_full;
    assign o_data     = r_data;
    assign o_complete = w_complete;
    assign o_loaded   = w_loaded;
    assign o_overflow = r_ovf;

endmodule

`default_nettype wire

// File: rtl/rangefinder_sample_writer.sv
//------------------------------------------------------------------------------
// Module   : rangefinder_sample_writer
// Purpose  : Captures a decimated ADC sample stream into a RAM through an
//            Avalon-MM write master. Optional level trigger selected with the
//            RANGEFINDER_SAMPLE_WRITER_TRIG_EN macro.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rangefinder_sample_writer
    import rangefinder_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] len_m1,
    input  logic [3:0]        decim,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic              avm_waitrequest,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W:0]   count
);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_len_m1;
    logic [3:0]        r_decim;
    logic [3:0]        r_dec_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W:0]   r_acc;

    logic              w_busy;
    logic              w_abort;
    logic              w_start;
    logic              w_room;
    logic              w_trig;
    logic              w_take;
    logic              w_full;
    logic              w_complete;
    logic              w_loaded;
    logic              w_last;
    logic [DATA_W-1:0] w_hold_data;
    logic              w_ovf;

    assign w_busy  = (r_state == ST_ARMED) || (r_state == ST_CAPTURE);
    assign w_abort = abort & w_busy;
    assign w_start = start & ((r_state == ST_IDLE) || (r_state == ST_DONE));
    // Stop accepting once len_m1+1 samples have entered the holding register.
    assign w_room  = (r_acc <= {1'b0, r_len_m1});

`ifdef RANGEFINDER_SAMPLE_WRITER_TRIG_EN
    logic [DATA_W-1:0] r_trig_level;

    // Trigger threshold is frozen for the duration of a capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_trig_level <= '0;
        end else if (w_start) begin
            r_trig_level <= trig_level;
        end
    end

    assign w_trig = (r_state == ST_ARMED) & sample_valid & (sample_data >= r_trig_level);
`else
    logic w_unused_trig;
    assign w_unused_trig = ^trig_level;
    assign w_trig        = 1'b0;
`endif

    // The triggering sample is taken as sample 0; afterwards every (decim+1)th valid one.
    assign w_take = ~w_abort & sample_valid & w_room &
                    (((r_state == ST_CAPTURE) && (r_dec_cnt == 4'd0)) || w_trig);
    assign w_last = w_complete & (r_count == {1'b0, r_len_m1});

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; abort overrides trigger and completion.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
`ifdef RANGEFINDER_SAMPLE_WRITER_TRIG_EN
                    w_next = ST_ARMED;
`else
                    w_next = ST_CAPTURE;
`endif
                end
            end
            ST_ARMED: begin
                if (abort) begin
                    w_next = ST_IDLE;
                end else if (w_trig) begin
                    w_next = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (abort) begin
                    w_next = ST_IDLE;
                end else if (w_last) begin
                    w_next = ST_DONE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Capture configuration, address/count bookkeeping and decimation.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_len_m1  <= '0;
            r_decim   <= '0;
            r_dec_cnt <= '0;
            r_addr    <= '0;
            r_count   <= '0;
            r_acc     <= '0;
        end else if (w_start) begin
            r_len_m1  <= len_m1;
            r_decim   <= decim;
            r_dec_cnt <= '0;
            r_addr    <= '0;
            r_count   <= '0;
            r_acc     <= '0;
        end else begin
            if (w_complete && !w_abort) begin
                // Address holds at the top word so a full-depth capture never wraps.
                r_addr  <= (r_addr == '1) ? r_addr : r_addr + ADDR_W'(1);
                r_count <= r_count + (ADDR_W+1)'(1);
            end
            if (w_loaded) begin
                r_acc <= r_acc + (ADDR_W+1)'(1);
            end
            if (((r_state == ST_CAPTURE) && sample_valid) || w_trig) begin
                r_dec_cnt <= (r_dec_cnt == r_decim) ? 4'd0 : r_dec_cnt + 4'd1;
            end
        end
    end

    rangefinder_sample_hold #(
        .DATA_W (DATA_W)
    ) u_hold (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_flush       (w_abort | w_start),
        .i_clr_ovf     (w_start),
        .i_load        (w_take),
        .i_data        (sample_data),
        .i_waitrequest (avm_waitrequest),
        .o_full        (w_full),
        .o_data        (w_hold_data),
        .o_complete    (w_complete),
        .o_loaded      (w_loaded),
        .o_overflow    (w_ovf)
    );

    assign avm_address    = r_addr;
    assign avm_chipselect = w_full;
    assign avm_write      = w_full;
    assign avm_writedata  = w_hold_data;
    assign busy           = w_busy;
    assign done           = (r_state == ST_DONE);
    assign overflow       = w_ovf;
    assign count          = r_count;

endmodule

`default_nettype wire

// File: tb/tb_rangefinder_sample_writer.sv
//------------------------------------------------------------------------------
// Module   : tb_rangefinder_sample_writer
// Purpose  : Directed self-checking bench for rangefinder_sample_writer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rangefinder_sample_writer;

    localparam int DW = 8;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic          abort;
    logic [AW-1:0] len_m1;
    logic [3:0]    decim;
    logic [DW-1:0] trig_level;
    logic          sample_valid;
    logic [DW-1:0] sample_data;
    logic [AW-1:0] avm_address;
    logic          avm_chipselect;
    logic          avm_write;
    logic [DW-1:0] avm_writedata;
    logic          avm_waitrequest;
    logic          busy;
    logic          done;
    logic          overflow;
    logic [AW:0]   count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rangefinder_sample_writer #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .abort           (abort),
        .len_m1          (len_m1),
        .decim           (decim),
        .trig_level      (trig_level),
        .sample_valid    (sample_valid),
        .sample_data     (sample_data),
        .avm_address     (avm_address),
        .avm_chipselect  (avm_chipselect),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_waitrequest (avm_waitrequest),
        .busy            (busy),
        .done            (done),
        .overflow        (overflow),
        .count           (count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d);
        chk({tag, "_write"}, avm_write, 1);
        chk({tag, "_cs"}, avm_chipselect, 1);
        chk({tag, "_addr"}, avm_address, a);
        chk({tag, "_data"}, avm_writedata, d);
    endtask

    task automatic begin_capture(input logic [AW-1:0] l, input logic [3:0] dc, input logic [DW-1:0] tl);
        len_m1 = l; decim = dc; trig_level = tl; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; len_m1 = '0; decim = '0;
        trig_level = '0; sample_valid = 1'b0; sample_data = '0; avm_waitrequest = 1'b0;
        #12;
        chk("rst_write", avm_write, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", count, 0);
        reset_n = 1'b1;
        tick();

        // Basic back-to-back capture of four samples
        begin_capture(8'd3, 4'd0, 8'h00);
        chk("t1_busy", busy, 1);
        chk("t1_idle_write", avm_write, 0);
        chk("t1_count0", count, 0);
        sample_valid = 1'b1;
        sample_data = 8'h10; tick(); wr("t1_w0", 8'd0, 8'h10); chk("t1_c0", count, 0);
        sample_data = 8'h11; tick(); wr("t1_w1", 8'd1, 8'h11); chk("t1_c1", count, 1);
        sample_data = 8'h12; tick(); wr("t1_w2", 8'd2, 8'h12); chk("t1_c2", count, 2);
        sample_data = 8'h13; tick(); wr("t1_w3", 8'd3, 8'h13); chk("t1_c3", count, 3);
        sample_valid = 1'b0; tick();
        chk("t1_done", done, 1);
        chk("t1_count", count, 4);
        chk("t1_ovf", overflow, 0);
        chk("t1_write_off", avm_write, 0);
        chk("t1_busy_off", busy, 0);

        // Decimation by 3, two samples
        begin_capture(8'd1, 4'd2, 8'h00);
        chk("t2_done_clr", done, 0);
        chk("t2_count_clr", count, 0);
        sample_valid = 1'b1;
        sample_data = 8'hA0; tick(); wr("t2_a0", 8'd0, 8'hA0);
        sample_data = 8'hA1; tick(); chk("t2_a1_write", avm_write, 0); chk("t2_a1_count", count, 1);
        sample_data = 8'hA2; tick(); chk("t2_a2_write", avm_write, 0);
        sample_data = 8'hA3; tick(); wr("t2_a3", 8'd1, 8'hA3);
        sample_data = 8'hA4; tick(); chk("t2_done", done, 1); chk("t2_count", count, 2);
        sample_data = 8'hA5; tick(); chk("t2_a5_write", avm_write, 0); chk("t2_hold_count", count, 2);
        sample_valid = 1'b0;

        // Three stalled cycles on the first write with continuous samples
        begin_capture(8'd3, 4'd0, 8'h00);
        sample_valid = 1'b1;
        sample_data = 8'h20; tick(); wr("t3_first", 8'd0, 8'h20);
        avm_waitrequest = 1'b1;
        sample_data = 8'h21; tick(); wr("t3_stall1", 8'd0, 8'h20); chk("t3_ovf", overflow, 1);
        sample_data = 8'h22; tick(); wr("t3_stall2", 8'd0, 8'h20);
        sample_data = 8'h23; tick(); wr("t3_stall3", 8'd0, 8'h20); chk("t3_stall_count", count, 0);
        avm_waitrequest = 1'b0;
        sample_data = 8'h24; tick(); wr("t3_w1", 8'd1, 8'h24); chk("t3_c1", count, 1);
        sample_data = 8'h25; tick(); wr("t3_w2", 8'd2, 8'h25);
        sample_data = 8'h26; tick(); wr("t3_w3", 8'd3, 8'h26);
        sample_data = 8'h27; tick();
        chk("t3_done", done, 1);
        chk("t3_count", count, 4);
        chk("t3_ovf_sticky", overflow, 1);
        chk("t3_write_off", avm_write, 0);
        sample_valid = 1'b0;

        // Abort with a stalled write in flight, then restart
        begin_capture(8'd7, 4'd0, 8'h00);
        chk("t4_ovf_clr", overflow, 0);
        sample_valid = 1'b1;
        sample_data = 8'h30; tick();
        sample_data = 8'h31; tick();
        sample_data = 8'h32; tick(); wr("t4_w2", 8'd2, 8'h32); chk("t4_c2", count, 2);
        avm_waitrequest = 1'b1; abort = 1'b1; sample_data = 8'h33; tick();
        abort = 1'b0; avm_waitrequest = 1'b0; sample_valid = 1'b0;
        chk("t4_abort_busy", busy, 0);
        chk("t4_abort_write", avm_write, 0);
        chk("t4_abort_done", done, 0);
        tick();
        chk("t4_idle_write", avm_write, 0);
        begin_capture(8'd7, 4'd0, 8'h00);
        chk("t4_re_count", count, 0);
        chk("t4_re_addr", avm_address, 0);
        sample_valid = 1'b1; sample_data = 8'h40; tick(); wr("t4_re_w0", 8'd0, 8'h40);
        sample_valid = 1'b0; abort = 1'b1; tick(); abort = 1'b0;
        chk("t4_end_busy", busy, 0);

`ifdef RANGEFINDER_SAMPLE_WRITER_TRIG_EN
        // Level trigger: first sample at or above 0x80 becomes sample 0
        begin_capture(8'd0, 4'd0, 8'h80);
        sample_valid = 1'b1;
        sample_data = 8'h10; tick(); chk("t5_below1", avm_write, 0); chk("t5_armed_busy", busy, 1);
        sample_data = 8'h7F; tick(); chk("t5_below2", avm_write, 0);
        sample_data = 8'h80; tick(); wr("t5_trig", 8'd0, 8'h80);
        sample_data = 8'h81; tick(); chk("t5_done", done, 1); chk("t5_count", count, 1);
        sample_valid = 1'b0;
`endif

        // Full-depth capture interrupted by reset during a stalled write
        begin_capture(8'd255, 4'd0, 8'h00);
        sample_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            sample_data = DW'(i + 8'h50);
            tick();
        end
        avm_waitrequest = 1'b1; tick();
        chk("t6_stalled_write", avm_write, 1);
        chk("t6_stalled_ovf", overflow, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_write", avm_write, 0);
        chk("t6_rst_cs", avm_chipselect, 0);
        chk("t6_rst_addr", avm_address, 0);
        chk("t6_rst_data", avm_writedata, 0);
        chk("t6_rst_count", count, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_ovf", overflow, 0);
        sample_valid = 1'b0; avm_waitrequest = 1'b0;
        #3 reset_n = 1'b1;
        tick();
        chk("t6_post_busy", busy, 0);
        begin_capture(8'd255, 4'd0, 8'h00);
        sample_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            sample_data = DW'(255 - i);
            tick();
            chk("t6_full_addr", avm_address, i);
            chk("t6_full_data", avm_writedata, 255 - i);
            chk("t6_full_write", avm_write, 1);
        end
        tick();
        sample_valid = 1'b0;
        chk("t6_full_done", done, 1);
        chk("t6_full_count", count, 256);
        chk("t6_full_write_off", avm_write, 0);
        chk("t6_full_addr_end", avm_address, 255);
        chk("t6_full_ovf", overflow, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
